// File: rtl/riscv_enc_pkg.sv
// Shared types and opcode constants for the RV32I instruction encoder.
// Optional range checking is enabled by defining INSTR_ENC_CHECK_EN.
package riscv_enc_pkg;

    typedef enum logic [3:0] {
        LW    = 4'd0,
        SW    = 4'd1,
        RTYPE = 4'd2,
        BTYPE = 4'd3,
        ITYPE = 4'd4,
        JAL   = 4'd5,
        AUIPC = 4'd6,
        LUI   = 4'd7,
        JALR  = 4'd8
    } instr_kind_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // kind stays raw so out-of-range codes can be flagged
    typedef struct packed {
        logic [3:0]  kind;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_desc_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: one descriptor in, one RV32I word out.
// Immediate range checks exist only when INSTR_ENC_CHECK_EN is defined.
module instr_pack
    import riscv_enc_pkg::*;
(
    input  enc_desc_t   desc_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        imm_err_o
);

    logic [31:0] im;
    logic        shift;
    logic [6:0]  f7;

    assign im    = desc_i.imm;
    assign shift = (desc_i.funct3 == 3'b001) ||
                   (desc_i.funct3 == 3'b101);
    assign f7    = {1'b0, desc_i.funct7b5, 5'b00000};

    // Field placement per instruction format
    always_comb begin
        word_o    = NOP;
        illegal_o = 1'b0;
        case (desc_i.kind)
            LW:
                word_o = {im[11:0], desc_i.rs1, 3'b010,
                          desc_i.rd, OP_LOAD};
            SW:
                word_o = {im[11:5], desc_i.rs2, desc_i.rs1,
                          3'b010, im[4:0], OP_STORE};
            RTYPE:
                word_o = {f7, desc_i.rs2, desc_i.rs1,
                          desc_i.funct3, desc_i.rd, OP_R};
            ITYPE:
                if (shift)
                    word_o = {f7, im[4:0], desc_i.rs1,
                              desc_i.funct3, desc_i.rd, OP_I};
                else
                    word_o = {im[11:0], desc_i.rs1,
                              desc_i.funct3, desc_i.rd, OP_I};
            BTYPE:
                word_o = {im[12], im[10:5], desc_i.rs2,
                          desc_i.rs1, desc_i.funct3,
                          im[4:1], im[11], OP_B};
            JAL:
                word_o = {im[20], im[10:1], im[11], im[19:12],
                          desc_i.rd, OP_JAL};
            JALR:
                word_o = {im[11:0], desc_i.rs1, 3'b000,
                          desc_i.rd, OP_JALR};
            AUIPC:
                word_o = {im[31:12], desc_i.rd, OP_AUIPC};
            LUI:
                word_o = {im[31:12], desc_i.rd, OP_LUI};
            default:
                illegal_o = 1'b1;
        endcase
    end

`ifdef INSTR_ENC_CHECK_EN
    logic signed [31:0] simm;
    logic               i_ok;
    logic               b_ok;
    logic               j_ok;

    assign simm = desc_i.imm;
    assign i_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign b_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094);
    assign j_ok = (simm >= -32'sd1048576) &&
                  (simm <= 32'sd1048575);

    // Flag immediates that do not survive truncation
    always_comb begin
        imm_err_o = 1'b0;
        case (desc_i.kind)
            LW, SW, JALR:
                imm_err_o = !i_ok;
            ITYPE:
                imm_err_o = shift ? (im[11:5] != 7'd0) : !i_ok;
            BTYPE:
                imm_err_o = !b_ok || im[0];
            JAL:
                imm_err_o = !j_ok || im[0];
            AUIPC, LUI:
                imm_err_o = (im[11:0] != 12'd0);
            default:
                imm_err_o = 1'b0;
        endcase
    end
`else
    assign imm_err_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Load-session sequencer: encodes descriptors and streams them to imem.
// err_imm is only ever raised when INSTR_ENC_CHECK_EN is defined.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64,
    parameter int          AW        = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_kind,
    input  logic [2:0]    in_funct3,
    input  logic          in_funct7b5,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [31:0]   out_data,
    output logic          busy,
    output logic          full,
    output logic          done,
    output logic          err_imm,
    output logic          err_kind
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FULL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [AW-1:0]  addr_q, addr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           vld_q;
    logic [31:0]    data_q;
    logic [AW-1:0]  oaddr_q;
    logic           busy_q, full_q, done_q;
    logic           err_imm_q, err_kind_q;

    enc_desc_t      desc;
    logic [31:0]    pk_word;
    logic           pk_illegal;
    logic           pk_imm_err;
    logic           accept;

    // Bundle the descriptor inputs for the packer
    always_comb begin
        desc          = '0;
        desc.kind     = in_kind;
        desc.funct3   = in_funct3;
        desc.funct7b5 = in_funct7b5;
        desc.rd       = in_rd;
        desc.rs1      = in_rs1;
        desc.rs2      = in_rs2;
        desc.imm      = in_imm;
    end

    instr_pack u_pack (
        .desc_i    (desc),
        .word_o    (pk_word),
        .illegal_o (pk_illegal),
        .imm_err_o (pk_imm_err)
    );

    assign in_ready = (state_q == S_LOAD) && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Address and count advance once per accepted descriptor
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (accept) begin
            addr_d  = addr_q + AW'(4);
            count_d = count_q + CW'(1);
        end
    end

    // Session FSM, counters and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= AW'(BASE_ADDR);
            count_q    <= '0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            oaddr_q    <= '0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
            err_imm_q  <= 1'b0;
            err_kind_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                vld_q   <= 1'b1;
                data_q  <= pk_word;
                oaddr_q <= addr_q;
            end else if (out_ready) begin
                vld_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        addr_q     <= AW'(BASE_ADDR);
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                        full_q     <= 1'b0;
                        err_imm_q  <= 1'b0;
                        err_kind_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    addr_q  <= addr_d;
                    count_q <= count_d;
                    if (accept) begin
                        err_imm_q  <= err_imm_q | pk_imm_err;
                        err_kind_q <= err_kind_q | pk_illegal;
                    end
                    if (count_d == CW'(DEPTH))
                        full_q <= 1'b1;
                    if (finish)
                        state_q <= S_DRAIN;
                    else if (count_d == CW'(DEPTH))
                        state_q <= S_FULL;
                end
                S_FULL: begin
                    if (finish)
                        state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!vld_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = vld_q;
    assign out_addr  = oaddr_q;
    assign out_data  = data_q;
    assign busy      = busy_q;
    assign full      = full_q;
    assign done      = done_q;
    assign err_imm   = err_imm_q;
    assign err_kind  = err_kind_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4, BASE 0x1000).
// err_imm expectations follow INSTR_ENC_CHECK_EN.
module tb_instr_encoder;
    import riscv_enc_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_kind = 4'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic        in_funct7b5 = 1'b0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        busy, full, done, err_imm, err_kind;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_addr = BASE;

    instr_encoder #(
        .BASE_ADDR (BASE),
        .DEPTH     (4),
        .AW        (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .finish      (finish),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .full        (full),
        .done        (done),
        .err_imm     (err_imm),
        .err_kind    (err_kind)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pop and compare every word the imem port takes
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL extra_word: got addr=%h data=%h, none expected",
                         out_addr, out_data);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if ({out_addr, out_data} !== e) begin
                    errors++;
                    $display("FAIL word: got addr=%h data=%h, required addr=%h data=%h",
                             out_addr, out_data, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] k, input logic [2:0] f3,
                         input logic f7, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] imm);
        in_valid    = 1'b1;
        in_kind     = k;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_rd       = rd;
        in_rs1      = r1;
        in_rs2      = r2;
        in_imm      = imm;
    endtask

    task automatic send(input logic [3:0] k, input logic [2:0] f3,
                        input logic f7, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] imm, input logic [31:0] w);
        bit got = 1'b0;
        drive(k, f3, f7, rd, r1, r2, imm);
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back({exp_addr, w});
                exp_addr += 32'd4;
                got = 1'b1;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept: in_ready stayed 0, required 1 (word %h)", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_addr = BASE;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: got %b required 1", busy);
        end
    endtask

    task automatic finish_session();
        bit seen = 1'b0;
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_pulse: done stayed 0, required 1");
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_busy: got %b required 0", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got %b required 0", done);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drained: %0d words outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_addr, out_data, busy, full, done,
             err_imm, err_kind, in_ready} !== 73'd0) begin
            errors++;
            $display("FAIL reset_outs: v=%b a=%h d=%h b=%b f=%b dn=%b ei=%b ek=%b r=%b required all 0",
                     out_valid, out_addr, out_data, busy, full, done,
                     err_imm, err_kind, in_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, done, in_ready} !== 4'd0) begin
            errors++;
            $display("FAIL idle_outs: v=%b b=%b dn=%b r=%b required 0",
                     out_valid, busy, done, in_ready);
        end
    endtask

    task automatic test_start_finish();
        @(posedge clk);
        #1;
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_finish: busy=%b done=%b required 0 0", busy, done);
        end
        start = 1'b1;
        finish = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_wins: busy=%b required 1", busy);
        end
        finish_session();
    endtask

    task automatic test_alu_mem();
        do_start();
        send(ITYPE, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== BASE) begin
            errors++;
            $display("FAIL latency: valid=%b addr=%h required 1 %h",
                     out_valid, out_addr, BASE);
        end
        send(RTYPE, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3);
        send(SW, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423);
        finish_session();
    endtask

    task automatic test_branch_jump();
        do_start();
        send(BTYPE, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd4, 32'hFE00_0EE3);
        send(JAL, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd8, 32'h0080_006F);
        finish_session();
    endtask

    task automatic test_back_to_back();
        do_start();
        out_ready = 1'b0;
        send(LUI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7);
        drive(JALR, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_data !== 32'h1234_52B7 || out_addr !== BASE) begin
                errors++;
                $display("FAIL stall: rdy=%b v=%b d=%h a=%h required 0 1 123452b7 %h",
                         in_ready, out_valid, out_data, out_addr, BASE);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(JALR, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4, 32'h0041_00E7);
        send(RTYPE, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3);
        send(LW, 3'b000, 1'b0, 5'd4, 5'd2, 5'd0, 32'd12, 32'h00C1_2203);
        finish_session();
    endtask

    task automatic test_full();
        bit blocked = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = (32'(i + 1) << 20) | 32'h0000_0093;
            send(ITYPE, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i + 1), w);
        end
        drive(ITYPE, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd9);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) blocked = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (!blocked) begin
            errors++;
            $display("FAIL fifth_blocked: in_ready=1 seen, required 0");
        end
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL full_flag: got %b required 1", full);
        end
        finish_session();
    endtask

    task automatic test_errors();
        logic exp_ei;
`ifdef INSTR_ENC_CHECK_EN
        exp_ei = 1'b1;
`else
        exp_ei = 1'b0;
`endif
        do_start();
        send(ITYPE, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093);
        checks++;
        if (err_imm !== exp_ei || err_kind !== 1'b0) begin
            errors++;
            $display("FAIL err_imm_set: ei=%b ek=%b required %b 0",
                     err_imm, err_kind, exp_ei);
        end
        send(ITYPE, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd1, 32'h0010_0113);
        checks++;
        if (err_imm !== exp_ei) begin
            errors++;
            $display("FAIL err_imm_sticky: got %b required %b", err_imm, exp_ei);
        end
        send(4'd15, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd7, 32'h0000_0013);
        checks++;
        if (err_kind !== 1'b1) begin
            errors++;
            $display("FAIL err_kind: got %b required 1", err_kind);
        end
        finish_session();
        checks++;
        if (err_kind !== 1'b1 || err_imm !== exp_ei) begin
            errors++;
            $display("FAIL err_hold_idle: ek=%b ei=%b required 1 %b",
                     err_kind, err_imm, exp_ei);
        end
        do_start();
        checks++;
        if (err_kind !== 1'b0 || err_imm !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: ek=%b ei=%b required 0 0", err_kind, err_imm);
        end
        finish_session();
    endtask

    task automatic test_reset_mid();
        do_start();
        out_ready = 1'b0;
        send(AUIPC, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_1000, 32'h0000_1097);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_addr, out_data, busy, full, done,
             err_imm, err_kind, in_ready} !== 73'd0) begin
            errors++;
            $display("FAIL reset_mid: v=%b a=%h d=%h b=%b r=%b required all 0",
                     out_valid, out_addr, out_data, busy, in_ready);
        end
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL after_reset: v=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_start_finish();
        test_alu_mem();
        test_branch_jump();
        test_back_to_back();
        test_full();
        test_errors();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
